// File: rtl/dmem_port_ctrl_pkg.sv
// Shared definitions for the data-memory port controller: FSM encodings,
// default timeout and the fill bit used for the error read value.
package dmem_port_ctrl_pkg;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_DONE = 2'd2;

    localparam int DMEM_DEFAULT_TIMEOUT = 15;

    // Every bit of the read value returned on a timeout.
    localparam logic DMEM_ERR_FILL = 1'b1;

endpackage

// File: rtl/dmem_port_ctrl_wait_counter.sv
// Wait-cycle counter for the data-memory port: counts cycles without an
// acknowledge and flags when the configured limit is reached.
module dmem_wait_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count,
    output logic       expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/dmem_port_ctrl.sv
// MEM-stage data-memory port controller: turns LWD/SWD strobes into a
// request/acknowledge bus transaction and stalls the pipeline until it ends.
module dmem_port_ctrl
    import dmem_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = DMEM_DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_readM,
    input  logic                  d_writeM,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  mem_readM,
    output logic                  mem_writeM,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [1:0]            dbgState
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic       opRead;
    logic       memReq;
    logic       inWait;
    logic [7:0] waitCount;
    logic       waitExpired;
    logic       timeoutHit;

    dmem_wait_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_waitCounter (
        .clk    (clk),
        .reset  (reset),
        .clear  (!inWait),
        .enable (inWait && !mem_ack),
        .count  (waitCount),
        .expired(waitExpired)
    );

    assign memReq = d_readM | d_writeM;
    assign inWait = (state == DMEM_WAIT);

    // The last WAIT cycle is the one whose increment would reach the limit,
    // so WAIT lasts exactly TIMEOUT_CYCLES cycles.
    assign timeoutHit = !mem_ack && ((waitCount == LAST_COUNT) || waitExpired);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DMEM_IDLE;
            opRead      <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (memReq) begin
                        mem_address <= addr;
                        mem_wdata   <= wdata;
                        opRead      <= d_readM;
                        if (d_readM && d_writeM) begin
                            err <= 1'b1;
                        end
                        state <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (mem_ack) begin
                        if (opRead) begin
                            rdata <= mem_rdata;
                        end
                        state <= DMEM_DONE;
                    end else if (timeoutHit) begin
                        err   <= 1'b1;
                        rdata <= {DATA_WIDTH{DMEM_ERR_FILL}};
                        state <= DMEM_DONE;
                    end
                end
                DMEM_DONE: state <= DMEM_IDLE;
                default:   state <= DMEM_IDLE;
            endcase
        end
    end

    // Bus handshake: the request strobe is held high for every WAIT cycle and
    // the transfer completes in the cycle mem_ack is high; ack elsewhere is ignored.
    assign mem_readM  = inWait && opRead;
    assign mem_writeM = inWait && !opRead;
    assign stall      = ((state == DMEM_IDLE) && memReq) || inWait;
    assign done       = (state == DMEM_DONE);
    assign dbgState   = state;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl: one instance with the default timeout
// and one with TIMEOUT_CYCLES = 3 for the no-acknowledge case.
module tb_dmem_port_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic        dReadM, dWriteM, memAck;
    logic [15:0] addr, wdata, memRdata;
    logic        stall, done, err, memReadM, memWriteM;
    logic [15:0] rdata, memAddress, memWdata;
    logic [1:0]  dbgState;

    logic        tReadM, tWriteM, tAck;
    logic [15:0] tAddr, tWdata, tMemRdata;
    logic        tStall, tDone, tErr, tMemReadM, tMemWriteM;
    logic [15:0] tRdata, tMemAddress, tMemWdata;
    logic [1:0]  tDbgState;

    logic [15:0] expQ[$];
    logic [15:0] expV;

    dmem_port_ctrl dut (
        .clk(clk), .reset(reset), .d_readM(dReadM), .d_writeM(dWriteM),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .err(err), .mem_readM(memReadM), .mem_writeM(memWriteM),
        .mem_address(memAddress), .mem_wdata(memWdata), .mem_rdata(memRdata),
        .mem_ack(memAck), .dbgState(dbgState)
    );

    dmem_port_ctrl #(.TIMEOUT_CYCLES(3)) dutT (
        .clk(clk), .reset(reset), .d_readM(tReadM), .d_writeM(tWriteM),
        .addr(tAddr), .wdata(tWdata), .stall(tStall), .done(tDone), .rdata(tRdata),
        .err(tErr), .mem_readM(tMemReadM), .mem_writeM(tMemWriteM),
        .mem_address(tMemAddress), .mem_wdata(tMemWdata), .mem_rdata(tMemRdata),
        .mem_ack(tAck), .dbgState(tDbgState)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (dbgState !== S_IDLE) begin $display("FAIL rst_state got=%0d exp=0", dbgState); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL rst_stall got=%b exp=0", stall); bad++; end
        total++; if (done !== 1'b0) begin $display("FAIL rst_done got=%b exp=0", done); bad++; end
        total++; if (err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", err); bad++; end
        total++; if (rdata !== 16'h0000) begin $display("FAIL rst_rdata got=%h exp=0000", rdata); bad++; end
        total++; if ({memReadM, memWriteM} !== 2'b00) begin $display("FAIL rst_strobes got=%b exp=00", {memReadM, memWriteM}); bad++; end
        total++; if ({memAddress, memWdata} !== 32'h0) begin $display("FAIL rst_bus got=%h exp=0", {memAddress, memWdata}); bad++; end
        total++; if (tDbgState !== S_IDLE) begin $display("FAIL rst_t_state got=%0d exp=0", tDbgState); bad++; end
    endtask

    task automatic test_lwd();
        cyc(); dReadM = 1'b1; addr = 16'h0040;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin $display("FAIL lwd_stall_c0 got=%b exp=1", stall); bad++; end
        total++; if (memReadM !== 1'b0) begin $display("FAIL lwd_rd_c0 got=%b exp=0", memReadM); bad++; end
        cyc(); memAck = 1'b1; memRdata = 16'h1234;
        @(negedge clk);
        total++; if ({stall, memReadM, done} !== 3'b110) begin $display("FAIL lwd_c1 got=%b exp=110", {stall, memReadM, done}); bad++; end
        total++; if (memAddress !== 16'h0040) begin $display("FAIL lwd_addr got=%h exp=0040", memAddress); bad++; end
        cyc(); memAck = 1'b0; memRdata = 16'h0000;
        @(negedge clk);
        total++; if ({done, stall, memReadM} !== 3'b100) begin $display("FAIL lwd_c2 got=%b exp=100", {done, stall, memReadM}); bad++; end
        total++; if (rdata !== 16'h1234) begin $display("FAIL lwd_rdata got=%h exp=1234", rdata); bad++; end
        total++; if (err !== 1'b0) begin $display("FAIL lwd_err got=%b exp=0", err); bad++; end
        cyc(); dReadM = 1'b0;
        @(negedge clk);
        total++; if ({dbgState, stall} !== {S_IDLE, 1'b0}) begin $display("FAIL lwd_c3 got=%b exp=000", {dbgState, stall}); bad++; end
    endtask

    task automatic test_swd();
        cyc(); dWriteM = 1'b1; addr = 16'h0041; wdata = 16'hBEEF;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin $display("FAIL swd_stall_c0 got=%b exp=1", stall); bad++; end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            addr = 16'hFF00 ^ 16'(i); wdata = 16'h0A00 ^ 16'(i);
            memAck = (i == 4); memRdata = 16'h5555;
            @(negedge clk);
            total++; if ({memWriteM, memReadM, stall, done} !== 4'b1010) begin $display("FAIL swd_strobe_c%0d got=%b exp=1010", i, {memWriteM, memReadM, stall, done}); bad++; end
            total++; if ({memAddress, memWdata} !== {16'h0041, 16'hBEEF}) begin $display("FAIL swd_bus_c%0d got=%h exp=0041beef", i, {memAddress, memWdata}); bad++; end
        end
        cyc(); memAck = 1'b0;
        @(negedge clk);
        total++; if ({done, stall, memWriteM} !== 3'b100) begin $display("FAIL swd_c5 got=%b exp=100", {done, stall, memWriteM}); bad++; end
        total++; if (rdata !== 16'h1234) begin $display("FAIL swd_rdata got=%h exp=1234", rdata); bad++; end
        cyc(); dWriteM = 1'b0;
    endtask

    task automatic test_back_to_back();
        cyc(); dReadM = 1'b1; addr = 16'h0010;
        expQ.push_back(16'hA5A5);
        cyc(); memAck = 1'b1; memRdata = 16'hA5A5;
        @(negedge clk);
        total++; if (memReadM !== 1'b1) begin $display("FAIL b2b_rd got=%b exp=1", memReadM); bad++; end
        cyc(); memAck = 1'b0;
        @(negedge clk);
        expV = expQ.pop_front();
        total++; if ({done, rdata} !== {1'b1, expV}) begin $display("FAIL b2b_ld_done got=%b/%h exp=1/%h", done, rdata, expV); bad++; end
        expQ.push_back(expV);
        cyc(); dReadM = 1'b0; dWriteM = 1'b1; addr = 16'h0011; wdata = 16'h0F0F;
        @(negedge clk);
        total++; if ({dbgState, stall} !== {S_IDLE, 1'b1}) begin $display("FAIL b2b_idle got=%b exp=001", {dbgState, stall}); bad++; end
        cyc(); memAck = 1'b1; memRdata = 16'h3C3C;
        @(negedge clk);
        total++; if ({memWriteM, memReadM, memWdata} !== {2'b10, 16'h0F0F}) begin $display("FAIL b2b_wr got=%h exp=20f0f", {memWriteM, memReadM, memWdata}); bad++; end
        cyc(); memAck = 1'b0;
        @(negedge clk);
        expV = expQ.pop_front();
        total++; if ({done, rdata} !== {1'b1, expV}) begin $display("FAIL b2b_st_done got=%b/%h exp=1/%h", done, rdata, expV); bad++; end
        cyc(); dWriteM = 1'b0;
        @(negedge clk);
        total++; if ({dbgState, stall} !== {S_IDLE, 1'b0}) begin $display("FAIL b2b_end got=%b exp=000", {dbgState, stall}); bad++; end
    endtask

    task automatic test_reset_wait();
        cyc(); dReadM = 1'b1; addr = 16'h0020;
        cyc();
        cyc(); reset = 1'b1;
        @(negedge clk);
        total++; if (memReadM !== 1'b1) begin $display("FAIL rw_pre got=%b exp=1", memReadM); bad++; end
        cyc(); reset = 1'b0; dReadM = 1'b0; memAck = 1'b1; memRdata = 16'h9999;
        @(negedge clk);
        total++; if ({memReadM, memWriteM, done, dbgState} !== 5'b00000) begin $display("FAIL rw_after got=%b exp=00000", {memReadM, memWriteM, done, dbgState}); bad++; end
        cyc(); memAck = 1'b0;
        @(negedge clk);
        total++; if ({done, dbgState, rdata} !== 19'h0) begin $display("FAIL rw_ignored got=%b/%0d/%h exp=0/0/0000", done, dbgState, rdata); bad++; end
    endtask

    task automatic test_timeout();
        cyc(); tReadM = 1'b1; tAddr = 16'h0100;
        @(negedge clk);
        total++; if (tStall !== 1'b1) begin $display("FAIL to_stall got=%b exp=1", tStall); bad++; end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            @(negedge clk);
            total++; if ({tDbgState, tMemReadM, tDone} !== {S_WAIT, 2'b10}) begin $display("FAIL to_wait_c%0d got=%b exp=0110", i, {tDbgState, tMemReadM, tDone}); bad++; end
        end
        cyc();
        @(negedge clk);
        total++; if ({tDone, tErr, tMemReadM} !== 3'b110) begin $display("FAIL to_done got=%b exp=110", {tDone, tErr, tMemReadM}); bad++; end
        total++; if (tRdata !== 16'hFFFF) begin $display("FAIL to_rdata got=%h exp=ffff", tRdata); bad++; end
        cyc(); tReadM = 1'b0; tWriteM = 1'b1; tWdata = 16'h1111;
        cyc(); tAck = 1'b1;
        @(negedge clk);
        total++; if (tMemWriteM !== 1'b1) begin $display("FAIL to_wr got=%b exp=1", tMemWriteM); bad++; end
        cyc(); tAck = 1'b0;
        @(negedge clk);
        total++; if ({tDone, tErr, tRdata} !== {2'b11, 16'hFFFF}) begin $display("FAIL to_sticky got=%b/%b/%h exp=1/1/ffff", tDone, tErr, tRdata); bad++; end
        cyc(); tWriteM = 1'b0;
        @(negedge clk);
        total++; if (tErr !== 1'b1) begin $display("FAIL to_err_hold got=%b exp=1", tErr); bad++; end
    endtask

    task automatic test_both_strobes();
        cyc(); dReadM = 1'b1; dWriteM = 1'b1; addr = 16'h0030;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin $display("FAIL both_stall got=%b exp=1", stall); bad++; end
        cyc(); memAck = 1'b1; memRdata = 16'h7777;
        @(negedge clk);
        total++; if ({memReadM, memWriteM, err} !== 3'b101) begin $display("FAIL both_wait got=%b exp=101", {memReadM, memWriteM, err}); bad++; end
        cyc(); memAck = 1'b0;
        @(negedge clk);
        total++; if ({done, err, rdata} !== {2'b11, 16'h7777}) begin $display("FAIL both_done got=%b/%b/%h exp=1/1/7777", done, err, rdata); bad++; end
        cyc(); dReadM = 1'b0; dWriteM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b1;
        dReadM = 1'b0; dWriteM = 1'b0; memAck = 1'b0;
        addr = '0; wdata = '0; memRdata = '0;
        tReadM = 1'b0; tWriteM = 1'b0; tAck = 1'b0;
        tAddr = '0; tWdata = '0; tMemRdata = '0;
        test_reset();
        test_lwd();
        test_swd();
        test_back_to_back();
        test_reset_wait();
        test_timeout();
        test_both_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
